txd_sched: RTL and testbench
============================

// Module: txd_sched
// PURPOSE
//  Schedules the single host TXD byte stream between two sources.
//  - ID replies: 4 bytes, sent on command 0x02.
//  - Captured sample words: from the memory stream, serialised per enabled byte group.
//  - Applies XON/XOFF flow control and the host reset command decoded by the host controller.
//  - Sits between the command decoder, the sample memory readout and the UART/SPI TXD link.
// PARAMETERS
//  MDW      32            memory word width; GRP=MDW/8 byte groups
//  ID_WORD  32'h31414C53  ID reply, sent MSB byte first ("1ALS")
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  ctl_valid       in   1    command strobe from decoder, one cycle per command
//  ctl_code        in   8    command code, qualified by ctl_valid
//  cfg_dis_groups  in   GRP  1 = byte group disabled (skipped on readout)
//  mem_tvalid      in   1    sample word valid
//  mem_tdata       in   MDW  sample word
//  mem_tready      out  1    sample word accepted when mem_tvalid & mem_tready
//  str_txd_tvalid  out  1    byte valid to host link
//  str_txd_tdata   out  8    byte to host link
//  str_txd_tready  in   1    link accepts byte
//  busy            out  1    state != IDLE or ID request pending
// BEHAVIOUR
//  Reset values (rst sampled on clk)
//   - str_txd_tvalid=0, str_txd_tdata=0, mem_tready=0, busy=0.
//   - flow_en=1 (XON), id_pend=0, state=IDLE.
//  Commands (only when ctl_valid=1)
//   - 0x11: flow_en<=1.  0x13: flow_en<=0.  0x02: id_pend<=1.
//   - 0x00: abort -> next cycle state=IDLE, tvalid=0, id_pend=0, word discarded; flow_en unchanged.
//   - All other codes: ignored.
//  FSM states: IDLE, ID, DATA.
//   - IDLE->ID: id_pend & flow_en; id_pend cleared, byte cnt=0. ID has priority over DATA.
//   - IDLE->DATA: mem transfer; word and lane mask ~cfg_dis_groups registered.
//   - If the lane mask is all-zero: word consumed, no bytes sent, stay IDLE.
//   - ID->IDLE: after 4th byte transfer. DATA->IDLE: after last enabled lane's transfer.
//  Handshakes
//   - mem_tready = (state==IDLE) & ~id_pend & flow_en. Combinational from registers only.
//   - mem_tready never depends on mem_tvalid.
//   - One idle bubble cycle is required between words.
//  Output timing
//   - Output byte is registered; first byte valid the cycle after mem transfer or ID entry.
//   - Lanes are sent ascending (bits 7:0 first); disabled lanes are skipped with no gap cycles.
//   - Next byte is presented the cycle after a transfer if flow_en=1.
//   - Once tvalid=1, tvalid and tdata are held until transfer. Exception: 0x00 abort drops tvalid.
//   - XOFF blocks presenting new bytes only; a byte already valid completes.
//   - 0x02 arriving in ID or DATA sets id_pend, served after the current reply/word.
//  Simultaneous events
//   - 0x00 in the same cycle as a TXD transfer: the byte counts as sent, then abort.
//   - 0x13 in the same cycle as a transfer: that byte completes, no further byte is presented.
//   - 0x02 while id_pend=1: merged; a single reply is sent.
// TESTING
//  - 0x02, tready=1 -> bytes 31,41,4C,53 on 4 consecutive cycles; busy falls after.
//  - Word 0xDDCCBBAA, dis_groups=4'b0010, tready=1 -> AA,CC,DD; one bubble; tready again.
//  - Word, then 0x13 after 1st byte, hold 20 cycles, then 0x11 -> no bytes while off; remaining lanes resume.
//  - tready=0 for 5 cycles on byte 2 -> tvalid/tdata stable all 5 cycles; no lane lost or duplicated.
//  - Word mid-send, 0x02 -> word finishes, then ID 4 bytes, then mem_tready=1.
//  - 0x00 mid-word and rst mid-ID -> tvalid=0 next cycle; IDLE; next word starts at lane 0.

Source files
------------

// File: rtl/txd_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : txd_sched_if                                               |
// | Description : Bundle of the command, sample-memory and host TXD signals  |
// |               that connect to txd_sched.                                 |
// |               Ports carried:                                             |
// |                 ctl_valid/ctl_code          command strobe and code      |
// |                 cfg_dis_groups [GRP]        1 = byte group skipped       |
// |                 mem_tvalid/tdata/tready     sample word stream           |
// |                 str_txd_tvalid/tdata/tready host byte stream             |
// |                 busy                        scheduler activity flag      |
// |               slave  : scheduler side                                    |
// |               master : environment side                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface txd_sched_if #(
  parameter int MDW = 32
) ();
  localparam int GRP = MDW / 8;

  logic           ctl_valid;
  logic [7:0]     ctl_code;
  logic [GRP-1:0] cfg_dis_groups;
  logic           mem_tvalid;
  logic [MDW-1:0] mem_tdata;
  logic           mem_tready;
  logic           str_txd_tvalid;
  logic [7:0]     str_txd_tdata;
  logic           str_txd_tready;
  logic           busy;

  modport slave (
    input  ctl_valid, ctl_code, cfg_dis_groups,
    input  mem_tvalid, mem_tdata,
    output mem_tready,
    output str_txd_tvalid, str_txd_tdata,
    input  str_txd_tready,
    output busy
  );

  modport master (
    output ctl_valid, ctl_code, cfg_dis_groups,
    output mem_tvalid, mem_tdata,
    input  mem_tready,
    input  str_txd_tvalid, str_txd_tdata,
    output str_txd_tready,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/txd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : txd_sched                                                  |
// | Description : Schedules the single host TXD byte stream between the ID   |
// |               reply (4 bytes, MSB first) and captured sample words that  |
// |               are serialised lane by lane (bits 7:0 first), skipping     |
// |               disabled byte groups. Applies XON/XOFF flow control and    |
// |               the abort command.                                         |
// |               Ports:                                                     |
// |                 clk   system clock                                       |
// |                 rst   synchronous active-high reset                      |
// |                 bus   txd_sched_if.slave (commands, config, memory       |
// |                       stream, host TXD stream, busy)                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module txd_sched #(
  parameter int          MDW     = 32,
  parameter logic [31:0] ID_WORD = 32'h31414C53
) (
  input  logic        clk,
  input  logic        rst,
  txd_sched_if.slave  bus
);

  localparam int GRP = MDW / 8;
  localparam int LW  = (GRP > 1) ? $clog2(GRP) : 1;

  localparam logic [7:0] C_CMD_ABORT = 8'h00;
  localparam logic [7:0] C_CMD_ID    = 8'h02;
  localparam logic [7:0] C_CMD_XON   = 8'h11;
  localparam logic [7:0] C_CMD_XOFF  = 8'h13;
  localparam logic [2:0] C_ID_LEN    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ID   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t         state_q,   state_d;
  logic           flow_en_q, flow_en_d;
  logic           id_pend_q, id_pend_d;
  logic [2:0]     cnt_q,     cnt_d;      // ID bytes presented so far
  logic [MDW-1:0] word_q,    word_d;
  logic [GRP-1:0] mask_q,    mask_d;     // lanes still to be presented
  logic           tvalid_q,  tvalid_d;
  logic [7:0]     tdata_q,   tdata_d;
  // Low for the first cycle out of reset so mem_tready starts deasserted
  // while still being a pure function of registers.
  logic           run_q,     run_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [LW-1:0] pick_lane(input logic [GRP-1:0] m);
    pick_lane = '0;
    for (int i = GRP - 1; i >= 0; i--) begin
      if (m[i]) pick_lane = LW'(i);
    end
  endfunction

  function automatic logic [7:0] lane_byte(input logic [MDW-1:0] w,
                                           input logic [LW-1:0]  l);
    lane_byte = w[{l, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = ID_WORD[31:24];
      2'd1:    id_byte = ID_WORD[23:16];
      2'd2:    id_byte = ID_WORD[15:8];
      default: id_byte = ID_WORD[7:0];
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic           cmd_abort, cmd_id, cmd_xon, cmd_xoff;
  logic           mem_tready_w, mem_xfer, txd_xfer;
  logic [GRP-1:0] new_mask;
  logic [LW-1:0]  new_lane, nxt_lane;

  always_comb begin
    cmd_abort = bus.ctl_valid && (bus.ctl_code == C_CMD_ABORT);
    cmd_id    = bus.ctl_valid && (bus.ctl_code == C_CMD_ID);
    cmd_xon   = bus.ctl_valid && (bus.ctl_code == C_CMD_XON);
    cmd_xoff  = bus.ctl_valid && (bus.ctl_code == C_CMD_XOFF);

    mem_tready_w = (state_q == S_IDLE) && !id_pend_q && flow_en_q && run_q;
    mem_xfer     = bus.mem_tvalid && mem_tready_w;
    txd_xfer     = tvalid_q && bus.str_txd_tready;

    new_mask = ~bus.cfg_dis_groups;
    new_lane = pick_lane(new_mask);
    nxt_lane = pick_lane(mask_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    mask_d    = mask_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    run_d     = 1'b1;

    // Flow state including this cycle's command: a same-cycle XOFF stops the
    // next byte from being presented after the current one completes.
    flow_en_d = flow_en_q;
    if (cmd_xon)  flow_en_d = 1'b1;
    if (cmd_xoff) flow_en_d = 1'b0;

    // A request arriving while one is already pending merges into it.
    id_pend_d = id_pend_q || cmd_id;

    case (state_q)
      S_IDLE: begin
        if (id_pend_q && flow_en_q) begin
          state_d   = S_ID;
          id_pend_d = 1'b0;
          tvalid_d  = 1'b1;
          tdata_d   = id_byte(2'd0);
          cnt_d     = 3'd1;
        end else if (mem_xfer) begin
          // An all-disabled mask consumes the word without leaving IDLE.
          if (|new_mask) begin
            state_d  = S_DATA;
            word_d   = bus.mem_tdata;
            tvalid_d = 1'b1;
            tdata_d  = lane_byte(bus.mem_tdata, new_lane);
            mask_d   = new_mask & ~(GRP'(1) << new_lane);
          end
        end
      end

      S_ID: begin
        // Act when the current byte leaves, or when paused by XOFF.
        if (txd_xfer || !tvalid_q) begin
          if (cnt_q == C_ID_LEN) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
          end else if (flow_en_d) begin
            tvalid_d = 1'b1;
            tdata_d  = id_byte(cnt_q[1:0]);
            cnt_d    = cnt_q + 3'd1;
          end else begin
            tvalid_d = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (txd_xfer || !tvalid_q) begin
          if (mask_q == '0) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
          end else if (flow_en_d) begin
            tvalid_d = 1'b1;
            tdata_d  = lane_byte(word_q, nxt_lane);
            mask_d   = mask_q & ~(GRP'(1) << nxt_lane);
          end else begin
            tvalid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    // Abort wins over everything except flow control; a byte transferred in
    // this same cycle has already been taken by the link.
    if (cmd_abort) begin
      state_d   = S_IDLE;
      tvalid_d  = 1'b0;
      id_pend_d = 1'b0;
      mask_d    = '0;
      cnt_d     = 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      flow_en_q <= 1'b1;
      id_pend_q <= 1'b0;
      cnt_q     <= 3'd0;
      word_q    <= '0;
      mask_q    <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= 8'h00;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      flow_en_q <= flow_en_d;
      id_pend_q <= id_pend_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      run_q     <= run_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_tready     = mem_tready_w;
  assign bus.str_txd_tvalid = tvalid_q;
  assign bus.str_txd_tdata  = tdata_q;
  assign bus.busy           = (state_q != S_IDLE) || id_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_txd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_txd_sched                                               |
// | Description : Self-checking bench for txd_sched: a per-cycle vector      |
// |               table for the ID reply and lane-masked word, followed by   |
// |               hand-written sequences for XOFF/XON, back-pressure, ID     |
// |               during a word, abort and reset mid-reply.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_txd_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  txd_sched_if #(.MDW(32)) bus ();

  txd_sched #(.MDW(32), .ID_WORD(32'h31414C53)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ctl_valid;
    logic [7:0]  ctl_code;
    logic [3:0]  dis;
    logic        mem_tvalid;
    logic [31:0] mem_tdata;
    logic        txd_tready;
    logic        e_tvalid;
    logic [7:0]  e_tdata;
    logic        e_mtready;
    logic        e_busy;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offer a word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] data, input logic [3:0] dis);
    bit ok = 0;
    bus.mem_tvalid     = 1'b1;
    bus.mem_tdata      = data;
    bus.cfg_dis_groups = dis;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_tready) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) chk("send_word_timeout", 32'd0, 32'd1);
    step();
    bus.mem_tvalid = 1'b0;
  endtask

  // Record every transferred byte until the scheduler is fully idle.
  task automatic collect(input int maxc);
    bit done = 0;
    got.delete();
    for (int i = 0; i < maxc; i++) begin
      if (bus.str_txd_tvalid && bus.str_txd_tready) got.push_back(bus.str_txd_tdata);
      if (!bus.str_txd_tvalid && !bus.busy && got.size() > 0) begin
        done = 1;
        break;
      end
      step();
    end
    if (!done) chk("collect_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_b%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
      else                chk($sformatf("%s_b%0d", name, i), 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    //         ctl code   dis   mv  mdata          rdy  ev   edata  emr  ebusy
    tbl[0]  = '{1, 8'h02, 4'h0, 0, 32'h0,         1,   0,   8'h00, 1,   0};
    tbl[1]  = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   0,   8'h00, 0,   1};
    tbl[2]  = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   1,   8'h31, 0,   1};
    tbl[3]  = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   1,   8'h41, 0,   1};
    tbl[4]  = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   1,   8'h4C, 0,   1};
    tbl[5]  = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   1,   8'h53, 0,   1};
    tbl[6]  = '{0, 8'h00, 4'h2, 1, 32'hDDCCBBAA,  1,   0,   8'h00, 1,   0};
    tbl[7]  = '{0, 8'h00, 4'h2, 0, 32'h0,         1,   1,   8'hAA, 0,   1};
    tbl[8]  = '{0, 8'h00, 4'h2, 0, 32'h0,         1,   1,   8'hCC, 0,   1};
    tbl[9]  = '{0, 8'h00, 4'h2, 0, 32'h0,         1,   1,   8'hDD, 0,   1};
    tbl[10] = '{0, 8'h00, 4'hF, 1, 32'h12345678,  1,   0,   8'h00, 1,   0};
    tbl[11] = '{1, 8'h55, 4'h0, 0, 32'h0,         1,   0,   8'h00, 1,   0};
    tbl[12] = '{0, 8'h00, 4'h0, 0, 32'h0,         1,   0,   8'h00, 1,   0};

    bus.ctl_valid      = 1'b0;
    bus.ctl_code       = 8'h00;
    bus.cfg_dis_groups = 4'h0;
    bus.mem_tvalid     = 1'b0;
    bus.mem_tdata      = 32'h0;
    bus.str_txd_tready = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    step();
    step();
    chk("rst_tvalid",  {31'd0, bus.str_txd_tvalid}, 32'd0);
    chk("rst_tdata",   {24'd0, bus.str_txd_tdata},  32'd0);
    chk("rst_mtready", {31'd0, bus.mem_tready},     32'd0);
    chk("rst_busy",    {31'd0, bus.busy},           32'd0);
    rst = 1'b0;
    step();

    // ---- vector table ----
    for (int v = 0; v < NV; v++) begin
      bus.ctl_valid      = tbl[v].ctl_valid;
      bus.ctl_code       = tbl[v].ctl_code;
      bus.cfg_dis_groups = tbl[v].dis;
      bus.mem_tvalid     = tbl[v].mem_tvalid;
      bus.mem_tdata      = tbl[v].mem_tdata;
      bus.str_txd_tready = tbl[v].txd_tready;
      chk($sformatf("v%0d_tvalid", v), {31'd0, bus.str_txd_tvalid}, {31'd0, tbl[v].e_tvalid});
      if (tbl[v].e_tvalid)
        chk($sformatf("v%0d_tdata", v), {24'd0, bus.str_txd_tdata}, {24'd0, tbl[v].e_tdata});
      chk($sformatf("v%0d_mtready", v), {31'd0, bus.mem_tready}, {31'd0, tbl[v].e_mtready});
      chk($sformatf("v%0d_busy", v), {31'd0, bus.busy}, {31'd0, tbl[v].e_busy});
      step();
    end
    bus.ctl_valid      = 1'b0;
    bus.mem_tvalid     = 1'b0;
    bus.cfg_dis_groups = 4'h0;

    // ---- XOFF after first byte, hold, then XON ----
    bus.str_txd_tready = 1'b1;
    send_word(32'h44332211, 4'h0);
    chk("xoff_first", {23'd0, bus.str_txd_tvalid, bus.str_txd_tdata}, {23'd0, 1'b1, 8'h11});
    bus.ctl_valid = 1'b1;
    bus.ctl_code  = 8'h13;
    step();
    bus.ctl_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("xoff_hold%0d", i), {31'd0, bus.str_txd_tvalid}, 32'd0);
      step();
    end
    bus.ctl_valid = 1'b1;
    bus.ctl_code  = 8'h11;
    step();
    bus.ctl_valid = 1'b0;
    collect(40);
    exp_q = '{8'h22, 8'h33, 8'h44};
    check_seq("xon_rest");

    // ---- back-pressure on byte 2 ----
    step();
    send_word(32'h44332211, 4'h0);
    step();
    bus.str_txd_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {23'd0, bus.str_txd_tvalid, bus.str_txd_tdata},
          {23'd0, 1'b1, 8'h22});
      step();
    end
    bus.str_txd_tready = 1'b1;
    collect(40);
    exp_q = '{8'h22, 8'h33, 8'h44};
    check_seq("bp_rest");

    // ---- ID request during a word ----
    step();
    send_word(32'h44332211, 4'h0);
    bus.ctl_valid = 1'b1;
    bus.ctl_code  = 8'h02;
    step();
    bus.ctl_valid = 1'b0;
    collect(60);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h31, 8'h41, 8'h4C, 8'h53};
    check_seq("word_then_id");
    chk("word_then_id_mtready", {31'd0, bus.mem_tready}, 32'd1);

    // ---- abort mid-word ----
    send_word(32'h44332211, 4'h0);
    step();
    bus.str_txd_tready = 1'b0;
    bus.ctl_valid      = 1'b1;
    bus.ctl_code       = 8'h00;
    step();
    bus.ctl_valid = 1'b0;
    chk("abort_tvalid",  {31'd0, bus.str_txd_tvalid}, 32'd0);
    chk("abort_busy",    {31'd0, bus.busy},           32'd0);
    chk("abort_mtready", {31'd0, bus.mem_tready},     32'd1);
    bus.str_txd_tready = 1'b1;
    send_word(32'h88776655, 4'h0);
    collect(40);
    exp_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    check_seq("after_abort");

    // ---- reset mid-ID ----
    step();
    bus.str_txd_tready = 1'b0;
    bus.ctl_valid      = 1'b1;
    bus.ctl_code       = 8'h02;
    step();
    bus.ctl_valid = 1'b0;
    step();
    chk("rid_first", {23'd0, bus.str_txd_tvalid, bus.str_txd_tdata}, {23'd0, 1'b1, 8'h31});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rid_tvalid", {31'd0, bus.str_txd_tvalid}, 32'd0);
    chk("rid_tdata",  {24'd0, bus.str_txd_tdata},  32'd0);
    chk("rid_busy",   {31'd0, bus.busy},           32'd0);
    step();
    bus.str_txd_tready = 1'b1;
    send_word(32'h44332211, 4'h8);
    collect(40);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_seq("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
